// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// One operation is in flight at a time. Each result is returned through a valid/ready response port.
module alu_arb_ctrl #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_cmd,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_cmd,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_cmd,
  input  logic [7:0] alu_result,
  input  logic       alu_ovr,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_ovr,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       launched;
  logic       last_grant;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] op_cmd;
  logic       op_id;
  logic       grant0;
  logic       grant1;

  // A tie goes to the requester that was not granted last.
  // last_grant = 1 means req1 was granted most recently.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || last_grant)) grant0 = 1'b1;
      else if (req1_valid)                           grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // NOTE: state registers use non-blocking assignments.
  // Every flop then samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      launched   <= 1'b0;
      last_grant <= 1'b1;
      op_a       <= 8'd0;
      op_b       <= 8'd0;
      op_cmd     <= 2'd0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'd0;
      rsp_ovr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a       <= grant1 ? req1_a   : req0_a;
            op_b       <= grant1 ? req1_b   : req0_b;
            op_cmd     <= grant1 ? req1_cmd : req0_cmd;
            op_id      <= grant1;
            last_grant <= grant1;
            wait_cnt   <= WAIT_LOAD;
            launched   <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The first EXEC cycle only launches the fresh operand registers into the ALU.
          // ALU_WAIT settle cycles are counted from the cycle after that.
          if (!launched) begin
            launched <= 1'b1;
          end else if (wait_cnt == 4'd0) begin
            rsp_result <= alu_result;
            rsp_ovr    <= alu_ovr;
            rsp_id     <= op_id;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_cmd   = op_cmd;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl with three instances, using ALU_WAIT = 1, 3 and 4.
// Expected responses are queued when a grant is seen and popped when rsp_valid appears.
module tb_alu_arb_ctrl;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0v[3], r1v[3], r0r[3], r1r[3];
  logic [7:0] r0a[3], r0b[3], r1a[3], r1b[3];
  logic [1:0] r0c[3], r1c[3];
  logic [7:0] aa[3], ab[3], ares[3];
  logic [1:0] ac[3];
  logic       aovr[3];
  logic       rv[3], rr[3], rid[3], rovr[3], bsy[3];
  logic [7:0] rres[3];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   w;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU.
  function automatic logic [8:0] alu_model(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      2'd0:    alu_model = {1'b0, a};
      2'd1:    alu_model = {(a < b), 8'(a - b)};
      2'd2:    alu_model = {1'b0, a} + {1'b0, b};
      default: alu_model = {1'b0, b} + {1'b0, b};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign {aovr[g], ares[g]} = alu_model(ac[g], aa[g], ab[g]);

    alu_arb_ctrl #(.ALU_WAIT(g == 0 ? 1 : (g == 1 ? 3 : 4))) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[g]), .req0_ready(r0r[g]), .req0_a(r0a[g]), .req0_b(r0b[g]), .req0_cmd(r0c[g]),
      .req1_valid(r1v[g]), .req1_ready(r1r[g]), .req1_a(r1a[g]), .req1_b(r1b[g]), .req1_cmd(r1c[g]),
      .alu_a(aa[g]), .alu_b(ab[g]), .alu_cmd(ac[g]), .alu_result(ares[g]), .alu_ovr(aovr[g]),
      .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_id(rid[g]), .rsp_result(rres[g]), .rsp_ovr(rovr[g]),
      .busy(bsy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit rq, input logic v, input logic [1:0] c,
                         input logic [7:0] a, input logic [7:0] b);
    if (rq) begin r1v[i] = v; r1c[i] = c; r1a[i] = a; r1b[i] = b; end
    else    begin r0v[i] = v; r0c[i] = c; r0a[i] = a; r0b[i] = b; end
  endtask

  task automatic check_reset(input int i, input string tag);
    check({tag, "_rsp_valid"},  rv[i],   1'b0);
    check({tag, "_rsp_id"},     rid[i],  1'b0);
    check({tag, "_rsp_result"}, rres[i], 8'd0);
    check({tag, "_rsp_ovr"},    rovr[i], 1'b0);
    check({tag, "_busy"},       bsy[i],  1'b0);
    check({tag, "_alu_a"},      aa[i],   8'd0);
    check({tag, "_alu_b"},      ab[i],   8'd0);
    check({tag, "_alu_cmd"},    ac[i],   2'd0);
    check({tag, "_ready0"},     r0r[i],  1'b0);
    check({tag, "_ready1"},     r1r[i],  1'b0);
  endtask

  // Bounded wait, starting away from the clock edge, for a grant that must go to rq.
  task automatic wait_grant(input int i, input bit rq, input string tag);
    int n = 0;
    while (!(r0r[i] || r1r[i]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready0"}, r0r[i], !rq);
    check({tag, "_ready1"}, r1r[i], rq);
  endtask

  // Drive one request and wait for its grant. Returns just after the handshake edge T,
  // after scrambling the operands.
  task automatic issue(input int i, input bit rq, input logic [1:0] c, input logic [7:0] a,
                       input logic [7:0] b, input exp_t e, input bit push, input string tag);
    set_req(i, rq, 1'b1, c, a, b);
    #1;
    wait_grant(i, rq, tag);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 set_req(i, rq, 1'b0, ~c, ~a, ~b);
  endtask

  // Called just after edge T. rsp_valid must stay low through edge T+lat-1,
  // be high after edge T+lat, and carry the queued payload.
  task automatic expect_rsp(input int i, input int lat, input string tag);
    exp_t e;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_early"}, rv[i], 1'b0);
    end
    @(negedge clk);
    check({tag, "_valid"},   rv[i], 1'b1);
    check({tag, "_noready"}, r0r[i] | r1r[i], 1'b0);
    check({tag, "_pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_id"},     rid[i],  e.id);
      check({tag, "_result"}, rres[i], e.res);
      check({tag, "_ovr"},    rovr[i], e.ovr);
    end
  endtask

  task automatic finish_rsp(input int i, input string tag);
    @(negedge clk);
    check({tag, "_released"}, rv[i],  1'b0);
    check({tag, "_idle"},      bsy[i], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(i, 1'b0, 1'b1, 2'd2, 8'h12, 8'h34);
      set_req(i, 1'b1, 1'b1, 2'd1, 8'h56, 8'h78);
      rr[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset(i, $sformatf("reset%0d", i));
    for (int i = 0; i < 3; i++) begin
      set_req(i, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
      set_req(i, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bsy[0], 1'b0);

    // Both requesters valid continuously: grants alternate, starting with req0.
    set_req(0, 1'b0, 1'b1, 2'd0, 8'h11, 8'h00);
    set_req(0, 1'b1, 1'b1, 2'd0, 8'h22, 8'h00);
    #1;
    for (int k = 0; k < 4; k++) begin
      w = (k % 2) == 1;
      wait_grant(0, w, $sformatf("rr%0d", k));
      sb.push_back(exp_t'{id: w, res: (w ? 8'h22 : 8'h11), ovr: 1'b0});
      @(posedge clk);
      #1;
      if (k == 3) begin
        set_req(0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        set_req(0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
      end
      expect_rsp(0, 2, $sformatf("rr%0d", k));
    end
    finish_rsp(0, "rr_end");

    // Directed operation results.
    issue(0, 1'b0, 2'd2, 8'd200, 8'd100, exp_t'{id: 1'b0, res: 8'd44, ovr: 1'b1}, 1'b1, "add");
    expect_rsp(0, 2, "add");
    finish_rsp(0, "add");
    issue(0, 1'b1, 2'd1, 8'd5, 8'd10, exp_t'{id: 1'b1, res: 8'd251, ovr: 1'b1}, 1'b1, "sub");
    expect_rsp(0, 2, "sub");
    finish_rsp(0, "sub");
    issue(0, 1'b1, 2'd3, 8'h01, 8'h90, exp_t'{id: 1'b1, res: 8'h20, ovr: 1'b1}, 1'b1, "dbl");
    expect_rsp(0, 2, "dbl");
    finish_rsp(0, "dbl");
    issue(0, 1'b1, 2'd0, 8'h5A, 8'h33, exp_t'{id: 1'b1, res: 8'h5A, ovr: 1'b0}, 1'b1, "pass");
    expect_rsp(0, 2, "pass");
    finish_rsp(0, "pass");
    check("retain_alu_a",   aa[0], 8'h5A);
    check("retain_alu_b",   ab[0], 8'h33);
    check("retain_alu_cmd", ac[0], 2'd0);

    // Response backpressure for 5 cycles, with a requester that withdraws before any grant.
    rr[0] = 1'b0;
    issue(0, 1'b0, 2'd2, 8'h01, 8'h02, exp_t'{id: 1'b0, res: 8'h03, ovr: 1'b0}, 1'b1, "hold");
    expect_rsp(0, 2, "hold");
    set_req(0, 1'b1, 1'b1, 2'd0, 8'h44, 8'h00);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) set_req(0, 1'b0, 1'b1, 2'd0, 8'h99, 8'h00);
      if (k == 3) set_req(0, 1'b0, 1'b0, 2'd0, 8'h99, 8'h00);
      @(negedge clk);
      check("hold_valid",  rv[0],   1'b1);
      check("hold_id",     rid[0],  1'b0);
      check("hold_result", rres[0], 8'h03);
      check("hold_ovr",    rovr[0], 1'b0);
      check("hold_ready",  r0r[0] | r1r[0], 1'b0);
      check("hold_busy",   bsy[0],  1'b1);
    end
    set_req(0, 1'b1, 1'b0, 2'd0, 8'h44, 8'h00);
    rr[0] = 1'b1;
    finish_rsp(0, "hold");
    check("withdraw_noready", r0r[0] | r1r[0], 1'b0);

    // req0 was granted last, so a tie now goes to req1.
    set_req(0, 1'b0, 1'b1, 2'd0, 8'h99, 8'h00);
    set_req(0, 1'b1, 1'b1, 2'd0, 8'h44, 8'h00);
    #1;
    wait_grant(0, 1'b1, "tie");
    sb.push_back(exp_t'{id: 1'b1, res: 8'h44, ovr: 1'b0});
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    set_req(0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    expect_rsp(0, 2, "tie");
    finish_rsp(0, "tie");

    // ALU_WAIT=3: the operands are changed after the handshake (issue scrambles them).
    issue(1, 1'b0, 2'd2, 8'd10, 8'd20, exp_t'{id: 1'b0, res: 8'd30, ovr: 1'b0}, 1'b1, "w3");
    expect_rsp(1, 4, "w3");
    finish_rsp(1, "w3");

    // ALU_WAIT=4: reset during EXEC discards the operation.
    issue(2, 1'b0, 2'd0, 8'h77, 8'h11, exp_t'(0), 1'b0, "abort");
    @(negedge clk);
    check("abort_busy",  bsy[2], 1'b1);
    check("abort_alu_a", aa[2],  8'h77);
    rst = 1'b1;
    @(negedge clk);
    check_reset(2, "abort_rst");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_rsp", rv[2], 1'b0);
    end
    issue(2, 1'b1, 2'd2, 8'h80, 8'h80, exp_t'{id: 1'b1, res: 8'h00, ovr: 1'b1}, 1'b1, "w4");
    expect_rsp(2, 5, "w4");
    finish_rsp(2, "w4");

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
